// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one RV32M divide/remainder request to a start/done divider and
// returns its result on a valid/ready response port.
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   flush_i                          kill the in-flight or pending operation
//   req_valid_i/req_ready_o          request handshake (op, a, b, tag)
//   div_start_o, div_op_type_o,      one-cycle start pulse plus registered op and operands
//   div_operand_a_o/_b_o
//   div_result_i, div_done_i,        divider completion; result and exception sampled with done
//   div_exception_valid_i/_cause_i
//   resp_valid_o/resp_ready_i        response handshake (result, tag, exc, cause, timeout)
//
// Configuration macro: DIV_ZERO_BYPASS_EN. When defined, a divide-by-zero request is answered
// directly (all-ones quotient or the dividend as remainder, with an illegal-instruction
// exception) without starting the divider. When undefined, it goes to the divider as usual.

`ifndef DEFAULT_DIV_LATENCY
`define DEFAULT_DIV_LATENCY 4
`endif

module div_issue_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LATENCY        = `DEFAULT_DIV_LATENCY,
  parameter int unsigned TAG_WIDTH      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  div_start_o,
  output logic [2:0]            div_op_type_o,
  output logic [DATA_WIDTH-1:0] div_operand_a_o,
  output logic [DATA_WIDTH-1:0] div_operand_b_o,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  input  logic                  div_done_i,
  input  logic                  div_exception_valid_i,
  input  logic [31:0]           div_exception_cause_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_result_o,
  output logic [TAG_WIDTH-1:0]  resp_tag_o,
  output logic                  resp_exc_o,
  output logic [31:0]           resp_cause_o,
  output logic                  resp_timeout_o
);

  localparam logic [31:0] CAUSE_ILLEGAL_INSTRUCTION = 32'd2;

`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  // Counter is wide enough for the watchdog limit and the nominal divider latency.
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > LATENCY) ? TIMEOUT_CYCLES : LATENCY;
  localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                  resp_exc_q, resp_exc_d;
  logic [31:0]           resp_cause_q, resp_cause_d;
  logic                  resp_timeout_q, resp_timeout_d;

  logic accept;
  logic wdog_hit;
  logic [CntW-1:0] cnt_inc;

  // Ready is masked during reset so every output reads 0 while rst_i is high.
  assign req_ready_o = (state_q == StIdle) && !flush_i && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wdog_hit    = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutVal);
  // Saturating increment: the counter parks at the limit instead of wrapping.
  assign cnt_inc     = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    tag_d          = tag_q;
    resp_result_d  = resp_result_q;
    resp_exc_d     = resp_exc_q;
    resp_cause_d   = resp_cause_q;
    resp_timeout_d = resp_timeout_q;

    if (accept) begin
      op_d  = req_op_i;
      a_d   = req_a_i;
      b_d   = req_b_i;
      tag_d = req_tag_i;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (BypassEn && (req_b_i == '0)) begin
            // REM/REMU (op[1]=1) return the dividend; DIV/DIVU return all ones.
            state_d        = StResp;
            resp_result_d  = req_op_i[1] ? req_a_i : '1;
            resp_exc_d     = 1'b1;
            resp_cause_d   = CAUSE_ILLEGAL_INSTRUCTION;
            resp_timeout_d = 1'b0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        // The start pulse is already out this cycle, so a flush must drain its done.
        state_d = flush_i ? StDrain : StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (div_done_i) begin
          if (flush_i) begin
            // Done already arrived, nothing left to drain.
            state_d = StIdle;
          end else begin
            state_d        = StResp;
            resp_result_d  = div_result_i;
            resp_exc_d     = div_exception_valid_i;
            resp_cause_d   = div_exception_cause_i;
            resp_timeout_d = 1'b0;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end else if (wdog_hit) begin
          state_d        = StResp;
          resp_result_d  = '0;
          resp_exc_d     = 1'b1;
          resp_cause_d   = CAUSE_ILLEGAL_INSTRUCTION;
          resp_timeout_d = 1'b1;
        end
      end
      StResp: begin
        if (flush_i || resp_ready_i) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        cnt_d = cnt_inc;
        if (div_done_i || wdog_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      tag_q          <= '0;
      resp_result_q  <= '0;
      resp_exc_q     <= 1'b0;
      resp_cause_q   <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      tag_q          <= tag_d;
      resp_result_q  <= resp_result_d;
      resp_exc_q     <= resp_exc_d;
      resp_cause_q   <= resp_cause_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign div_start_o     = (state_q == StIssue);
  assign div_op_type_o   = op_q;
  assign div_operand_a_o = a_q;
  assign div_operand_b_o = b_q;

  assign resp_valid_o    = (state_q == StResp);
  assign resp_result_o   = resp_result_q;
  assign resp_tag_o      = tag_q;
  assign resp_exc_o      = resp_exc_q;
  assign resp_cause_o    = resp_cause_q;
  assign resp_timeout_o  = resp_timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a small divider model (done LATENCY cycles after start).
module tb_div_issue_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned TO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic          div_start;
  logic [2:0]    div_op;
  logic [DW-1:0] div_a, div_b;
  logic [DW-1:0] div_result;
  logic          div_done;
  logic          div_exc_v;
  logic [31:0]   div_exc_cause;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_result;
  logic [TW-1:0] resp_tag;
  logic          resp_exc;
  logic [31:0]   resp_cause;
  logic          resp_timeout;

  int total = 0;
  int bad   = 0;

  // Divider model
  logic          mdl_en;
  logic          mdl_busy;
  logic [3:0]    mdl_cnt;
  logic          mdl_done;
  logic [DW-1:0] mdl_res;
  logic          stray_done;

  always #5 clk = ~clk;

  assign div_done      = mdl_done | stray_done;
  assign div_result    = mdl_res;
  assign div_exc_v     = 1'b0;
  assign div_exc_cause = 32'd0;

  div_issue_ctrl #(
    .DATA_WIDTH    (DW),
    .LATENCY       (LAT),
    .TAG_WIDTH     (TW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .req_valid_i          (req_valid),
    .req_ready_o          (req_ready),
    .req_op_i             (req_op),
    .req_a_i              (req_a),
    .req_b_i              (req_b),
    .req_tag_i            (req_tag),
    .div_start_o          (div_start),
    .div_op_type_o        (div_op),
    .div_operand_a_o      (div_a),
    .div_operand_b_o      (div_b),
    .div_result_i         (div_result),
    .div_done_i           (div_done),
    .div_exception_valid_i(div_exc_v),
    .div_exception_cause_i(div_exc_cause),
    .resp_valid_o         (resp_valid),
    .resp_ready_i         (resp_ready),
    .resp_result_o        (resp_result),
    .resp_tag_o           (resp_tag),
    .resp_exc_o           (resp_exc),
    .resp_cause_o         (resp_cause),
    .resp_timeout_o       (resp_timeout)
  );

  function automatic logic [DW-1:0] ref_div(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    if (b == 0) return op[1] ? a : '1;
    case (op)
      3'b100:  return DW'($signed(a) / $signed(b));
      3'b101:  return a / b;
      3'b110:  return DW'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Done goes high LAT cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= '0;
      mdl_done <= 1'b0;
      mdl_res  <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start && mdl_en) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 4'd1;
      end else if (mdl_busy) begin
        if (mdl_cnt == 4'(LAT - 1)) begin
          mdl_done <= 1'b1;
          mdl_res  <= ref_div(div_op, div_a, div_b);
          mdl_busy <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt + 4'd1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request in cycle T and returns in cycle T+1 with valid dropped.
  task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, output logic rdy);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    rdy       = req_ready;
    tick();
    req_valid = 1'b0;
  endtask

  // From cycle T+1, steps until resp_valid; returns its cycle offset from T (-1 if none).
  task automatic wait_resp(output int first, output int starts);
    first  = -1;
    starts = 0;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (div_start) starts++;
      if (resp_valid) begin
        first = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({req_ready, div_start, resp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 000", {req_ready, div_start, resp_valid});
    end
    total++;
    if ({div_op, div_a, div_b, resp_result} !== '0) begin
      bad++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0", div_op, div_a, div_b, resp_result);
    end
    total++;
    if ({resp_tag, resp_exc, resp_cause, resp_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_resp got %h/%b/%h/%b want 0", resp_tag, resp_exc, resp_cause,
               resp_timeout);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_divu;
    logic rdy;
    int first, starts;
    send(3'b101, 32'd100, 32'd7, 5'd3, rdy);
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL divu_accept_ready got %b want 1", rdy);
    end
    total++;
    if ({div_start, div_op, div_a, div_b} !== {1'b1, 3'b101, 32'd100, 32'd7}) begin
      bad++;
      $display("FAIL divu_start got %b/%b/%0d/%0d want 1/101/100/7", div_start, div_op, div_a,
               div_b);
    end
    wait_resp(first, starts);
    total++;
    if (first !== 6) begin
      bad++;
      $display("FAIL divu_resp_cycle got T+%0d want T+6", first);
    end
    total++;
    if (starts !== 0) begin
      bad++;
      $display("FAIL divu_extra_starts got %0d want 0", starts);
    end
    total++;
    if ({resp_result, resp_tag, resp_exc, resp_timeout} !== {32'd14, 5'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL divu_resp got %0d/%0d/%b/%b want 14/3/0/0", resp_result, resp_tag, resp_exc,
               resp_timeout);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL divu_handshake got %b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_resp_hold;
    logic rdy;
    int first, starts;
    bit stable;
    send(3'b101, 32'd1000, 32'd10, 5'd9, rdy);
    wait_resp(first, starts);
    total++;
    if (first !== 6) begin
      bad++;
      $display("FAIL hold_resp_cycle got T+%0d want T+6", first);
    end
    stable = 1'b1;
    req_valid = 1'b1;
    req_b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_result === 32'd100 &&
            resp_tag === 5'd9 && resp_exc === 1'b0 && resp_timeout === 1'b0))
        stable = 1'b0;
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL hold_stable got %b want 1 (last %0d tag %0d)", stable, resp_result, resp_tag);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++;
    if ({resp_valid, req_ready, div_start} !== 3'b010) begin
      bad++;
      $display("FAIL hold_release got %b want 010", {resp_valid, req_ready, div_start});
    end
  endtask

  task automatic test_div_zero(input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] exp_res, input logic [TW-1:0] tag);
    logic rdy;
    int first, starts;
    send(op, a, 32'd0, tag, rdy);
`ifdef DIV_ZERO_BYPASS_EN
    total++;
    if ({resp_valid, div_start} !== 2'b10) begin
      bad++;
      $display("FAIL zero_bypass_t1 got %b want 10", {resp_valid, div_start});
    end
    total++;
    if ({resp_result, resp_exc, resp_cause, resp_timeout} !== {exp_res, 1'b1, 32'd2, 1'b0}) begin
      bad++;
      $display("FAIL zero_bypass_resp got %h/%b/%0d/%b want %h/1/2/0", resp_result, resp_exc,
               resp_cause, resp_timeout, exp_res);
    end
    starts = 0;
    first  = 0;
`else
    total++;
    if (div_start !== 1'b1) begin
      bad++;
      $display("FAIL zero_start got %b want 1", div_start);
    end
    wait_resp(first, starts);
    total++;
    if (first !== 6) begin
      bad++;
      $display("FAIL zero_resp_cycle got T+%0d want T+6", first);
    end
    total++;
    if ({resp_result, resp_exc, resp_timeout} !== {exp_res, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL zero_resp got %h/%b/%b want %h/0/0", resp_result, resp_exc, resp_timeout,
               exp_res);
    end
`endif
    total++;
    if (resp_tag !== tag) begin
      bad++;
      $display("FAIL zero_tag got %0d want %0d", resp_tag, tag);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_flush;
    logic rdy;
    int first, starts;
    bit no_resp;
    logic rdy3, rdy6;
    flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_ready got %b want 0", req_ready);
    end
    flush = 1'b0;
    send(3'b101, 32'd50, 32'd5, 5'd1, rdy);
    total++;
    if (div_start !== 1'b1) begin
      bad++;
      $display("FAIL flush_start got %b want 1", div_start);
    end
    tick();
    flush = 1'b1;
    no_resp = 1'b1;
    rdy3 = 1'bx;
    rdy6 = 1'bx;
    for (int i = 3; i <= 8; i++) begin
      tick();
      flush = 1'b0;
      if (resp_valid !== 1'b0) no_resp = 1'b0;
      if (i == 3) rdy3 = req_ready;
      if (i == 6) rdy6 = req_ready;
    end
    total++;
    if (no_resp !== 1'b1) begin
      bad++;
      $display("FAIL flush_no_resp got %b want 1", no_resp);
    end
    total++;
    if ({rdy3, rdy6} !== 2'b01) begin
      bad++;
      $display("FAIL flush_drain_ready got %b want 01", {rdy3, rdy6});
    end
    send(3'b101, 32'd81, 32'd9, 5'd2, rdy);
    wait_resp(first, starts);
    total++;
    if ({first, resp_result, resp_tag} !== {32'd6, 32'd9, 5'd2}) begin
      bad++;
      $display("FAIL flush_next got T+%0d/%0d/%0d want T+6/9/2", first, resp_result, resp_tag);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    logic rdy;
    int first, starts;
    mdl_en = 1'b0;
    send(3'b101, 32'd10, 32'd2, 5'd4, rdy);
    wait_resp(first, starts);
    total++;
    if (first !== 11) begin
      bad++;
      $display("FAIL timeout_cycle got T+%0d want T+11", first);
    end
    total++;
    if ({resp_timeout, resp_result, resp_exc, resp_cause, resp_tag} !==
        {1'b1, 32'd0, 1'b1, 32'd2, 5'd4}) begin
      bad++;
      $display("FAIL timeout_resp got %b/%h/%b/%0d/%0d want 1/0/1/2/4", resp_timeout,
               resp_result, resp_exc, resp_cause, resp_tag);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mdl_en = 1'b1;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_release got %b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid;
    logic rdy;
    bit no_resp;
    send(3'b101, 32'd20, 32'd4, 5'd5, rdy);
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, div_start, resp_valid, div_op, div_a, div_b, resp_tag} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got %b%b%b/%h/%h/%h/%h want 0", req_ready, div_start,
               resp_valid, div_op, div_a, div_b, resp_tag);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got %b want 1", req_ready);
    end
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    no_resp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 1'b0 || div_start !== 1'b0) no_resp = 1'b0;
      tick();
    end
    total++;
    if ({no_resp, req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_stray_done got %b want 11", {no_resp, req_ready});
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    mdl_en     = 1'b1;
    stray_done = 1'b0;
    test_reset();
    test_divu();
    test_resp_hold();
    test_div_zero(3'b100, 32'd5, 32'hFFFF_FFFF, 5'd7);
    test_div_zero(3'b111, 32'h0000_1234, 32'h0000_1234, 5'd8);
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
